// File: rtl/vdp_pkg.sv
// vdp_pkg: shared VRAM arbiter types, sizes and lane helpers
package vdp_pkg;
  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_LANES = 8;
  localparam int READ_LAT_DEF = 2;
  localparam int FIFO_DEPTH_DEF = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_BG, OWN_SPR, OWN_CPU} owner_t;
  typedef logic [VRAM_LANES-1:0][VRAM_ADDR_W-1:0] lanes_addr_t;
  typedef logic [VRAM_LANES-1:0][7:0] lanes_data_t;
  typedef struct packed {
    logic we;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [7:0] wdata;
  } cpu_op_t;
  // writes use lane 0 only; reads broadcast the address across every lane
  function automatic lanes_addr_t cpu_lanes(input cpu_op_t op);
    cpu_lanes = op.we ? lanes_addr_t'(op.addr) : {VRAM_LANES{op.addr}};
  endfunction
endpackage

// File: rtl/vram_cpu_fifo.sv
// vram_cpu_fifo: synchronous FIFO of CPU VRAM operations with occupancy count
module vram_cpu_fifo
  import vdp_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  cpu_op_t                wdata_i,
  output cpu_op_t                rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  cpu_op_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: one VRAM op per cycle between background, sprite and CPU, with owner-tagged read returns
module vram_arbiter
  import vdp_pkg::*;
#(
  parameter int READ_LAT = READ_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    screen_busy,
  input  logic                                    bg_req,
  input  logic [VRAM_LANES-1:0][VRAM_ADDR_W-1:0]  bg_addr,
  input  logic                                    spr_req,
  input  logic [VRAM_LANES-1:0][VRAM_ADDR_W-1:0]  spr_addr,
  input  logic                                    cpu_req,
  input  logic                                    cpu_we,
  input  logic [VRAM_ADDR_W-1:0]                  cpu_addr,
  input  logic [7:0]                              cpu_wdata,
  output logic                                    cpu_ready,
  output logic [VRAM_LANES-1:0][VRAM_ADDR_W-1:0]  vram_addr,
  output logic                                    vram_rd,
  output logic                                    vram_we,
  output logic [7:0]                              vram_wdata,
  input  logic [VRAM_LANES-1:0][7:0]              vram_rdata,
  output logic                                    bg_rvalid,
  output logic                                    spr_rvalid,
  output logic                                    cpu_rvalid,
  output logic [VRAM_LANES-1:0][7:0]              rdata,
  output logic [$clog2(FIFO_DEPTH):0]             fifo_count,
  output logic                                    spr_overrun,
  input  logic                                    ovr_clr
);
  cpu_op_t head;
  logic fifo_empty, fifo_full;
  logic spr_pend_q, spr_pend_d, ovr_q, ovr_d;
  logic [VRAM_LANES-1:0][VRAM_ADDR_W-1:0] spr_addr_q, spr_sel;
  logic spr_have, cpu_have, go_bg, go_spr, go_cpu;
  owner_t tag_d, tail;
  owner_t tag_q [READ_LAT];
  logic bg_rvalid_q, spr_rvalid_q, cpu_rvalid_q;
  logic [VRAM_LANES-1:0][7:0] rdata_q;
  vram_cpu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(cpu_req & cpu_ready),
    .pop_i(go_cpu),
    .wdata_i({cpu_we, cpu_addr, cpu_wdata}),
    .rdata_o(head),
    .empty_o(fifo_empty),
    .full_o(fifo_full),
    .count_o(fifo_count)
  );
  assign cpu_ready = ~fifo_full;
  assign tail = tag_q[READ_LAT-1];
  assign bg_rvalid = bg_rvalid_q;
  assign spr_rvalid = spr_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign rdata = rdata_q;
  assign spr_overrun = ovr_q;
  // a waiting sprite takes precedence over a fresh one; the fresh one is then an overrun
  always_comb begin
    spr_have = spr_pend_q | spr_req;
    cpu_have = ~fifo_empty;
    spr_sel = spr_pend_q ? spr_addr_q : spr_addr;
    go_bg = ~rst & bg_req & (screen_busy | ~(cpu_have | spr_have));
    go_spr = ~rst & spr_have & (screen_busy ? ~bg_req : ~cpu_have);
    go_cpu = ~rst & cpu_have & (~screen_busy | ~(bg_req | spr_have));
    tag_d = go_bg ? OWN_BG : go_spr ? OWN_SPR : (go_cpu & ~head.we) ? OWN_CPU : OWN_NONE;
    vram_rd = tag_d != OWN_NONE;
    vram_we = go_cpu & head.we;
    vram_addr = go_bg ? bg_addr : go_spr ? spr_sel : go_cpu ? cpu_lanes(head) : '0;
    vram_wdata = vram_we ? head.wdata : '0;
    spr_pend_d = spr_have & ~go_spr;
    ovr_d = (spr_req & spr_pend_q) | (ovr_q & ~ovr_clr);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      spr_pend_q <= 1'b0;
      spr_addr_q <= '0;
      ovr_q <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) tag_q[i] <= OWN_NONE;
      bg_rvalid_q <= 1'b0;
      spr_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      spr_pend_q <= spr_pend_d;
      spr_addr_q <= spr_sel;
      ovr_q <= ovr_d;
      tag_q[0] <= tag_d;
      for (int i = 1; i < READ_LAT; i++) tag_q[i] <= tag_q[i-1];
      bg_rvalid_q <= tail == OWN_BG;
      spr_rvalid_q <= tail == OWN_SPR;
      cpu_rvalid_q <= tail == OWN_CPU;
      if (tail != OWN_NONE) rdata_q <= vram_rdata;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios plus randomized traffic against a queue-based reference model
module tb_vram_arbiter;
  import vdp_pkg::*;
  localparam int READ_LAT = 2;
  localparam int FIFO_DEPTH = 4;
  typedef struct {int due; owner_t own; lanes_data_t data;} exp_t;
  typedef struct {int due; lanes_data_t data;} env_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic screen_busy, bg_req, spr_req, cpu_req, cpu_we, ovr_clr;
  lanes_addr_t bg_addr, spr_addr, vram_addr;
  logic [13:0] cpu_addr;
  logic [7:0] cpu_wdata, vram_wdata;
  lanes_data_t vram_rdata, rdata;
  logic cpu_ready, vram_rd, vram_we, bg_rvalid, spr_rvalid, cpu_rvalid, spr_overrun;
  logic [2:0] fifo_count;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int iss[4];
  int rv[4];
  logic m_pend, m_ovr;
  lanes_addr_t m_paddr;
  cpu_op_t cq[$];
  exp_t exp_q[$];
  env_t env_q[$];
  bit [7:0] env_mem [16384];
  bit [7:0] ref_mem [16384];
  logic s_rd, s_we, s_ready, s_ovr, s_bgv, s_sprv, s_cpuv;
  lanes_addr_t s_addr;
  lanes_data_t s_rdata;
  logic [7:0] s_wd;
  logic [2:0] s_cnt;
  always #5 clk = ~clk;
  vram_arbiter #(.READ_LAT(READ_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .screen_busy(screen_busy),
    .bg_req(bg_req), .bg_addr(bg_addr), .spr_req(spr_req), .spr_addr(spr_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .bg_rvalid(bg_rvalid),
    .spr_rvalid(spr_rvalid), .cpu_rvalid(cpu_rvalid), .rdata(rdata),
    .fifo_count(fifo_count), .spr_overrun(spr_overrun), .ovr_clr(ovr_clr)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [13:0] raddr();
    return 14'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 14'h3FF0 : 14'h0);
  endfunction
  // one clock cycle: compare DUT against the model at mid-cycle, then advance both
  task automatic step();
    owner_t w;
    logic e_rd, e_we, e_ready, e_bgv, e_sprv, e_cpuv, sc, cc;
    logic [7:0] e_wd;
    lanes_addr_t e_addr;
    lanes_data_t d_env, d_ref;
    exp_t e;
    env_t ev;
    cpu_op_t op;
    @(negedge clk);
    if (rst) begin
      foreach (exp_q[i]) iss[exp_q[i].own]--;
      exp_q.delete();
      cq.delete();
      m_pend = 1'b0;
      m_ovr = 1'b0;
    end
    e_bgv = 1'b0;
    e_sprv = 1'b0;
    e_cpuv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      e_bgv = e.own == OWN_BG;
      e_sprv = e.own == OWN_SPR;
      e_cpuv = e.own == OWN_CPU;
      check("rdata", rdata, e.data);
    end
    check("bg_rvalid", bg_rvalid, e_bgv);
    check("spr_rvalid", spr_rvalid, e_sprv);
    check("cpu_rvalid", cpu_rvalid, e_cpuv);
    rv[OWN_BG] += int'(bg_rvalid);
    rv[OWN_SPR] += int'(spr_rvalid);
    rv[OWN_CPU] += int'(cpu_rvalid);
    e_ready = cq.size() < FIFO_DEPTH;
    sc = m_pend || spr_req;
    cc = cq.size() > 0;
    w = OWN_NONE;
    if (!rst) begin
      if (screen_busy) w = bg_req ? OWN_BG : sc ? OWN_SPR : cc ? OWN_CPU : OWN_NONE;
      else w = cc ? OWN_CPU : sc ? OWN_SPR : bg_req ? OWN_BG : OWN_NONE;
    end
    op = cc ? cq[0] : '0;
    e_rd = w == OWN_BG || w == OWN_SPR || (w == OWN_CPU && !op.we);
    e_we = w == OWN_CPU && op.we;
    e_addr = '0;
    e_wd = 8'h00;
    if (w == OWN_BG) e_addr = bg_addr;
    else if (w == OWN_SPR) e_addr = m_pend ? m_paddr : spr_addr;
    else if (w == OWN_CPU) for (int i = 0; i < 8; i++) if (i == 0 || !op.we) e_addr[i] = op.addr;
    if (e_we) e_wd = op.wdata;
    check("vram_rd", vram_rd, e_rd);
    check("vram_we", vram_we, e_we);
    check("vram_addr", vram_addr, e_addr);
    check("vram_wdata", vram_wdata, e_wd);
    check("cpu_ready", cpu_ready, e_ready);
    check("fifo_count", fifo_count, cq.size());
    check("spr_overrun", spr_overrun, m_ovr);
    s_rd = vram_rd; s_we = vram_we; s_ready = cpu_ready; s_ovr = spr_overrun;
    s_bgv = bg_rvalid; s_sprv = spr_rvalid; s_cpuv = cpu_rvalid;
    s_addr = vram_addr; s_rdata = rdata; s_wd = vram_wdata; s_cnt = fifo_count;
    if (vram_we) env_mem[vram_addr[0]] = vram_wdata;
    if (vram_rd) begin
      for (int i = 0; i < 8; i++) d_env[i] = env_mem[vram_addr[i]];
      env_q.push_back('{cyc + READ_LAT, d_env});
    end
    if (!rst) begin
      if (e_rd) begin
        for (int i = 0; i < 8; i++) d_ref[i] = ref_mem[e_addr[i]];
        exp_q.push_back('{cyc + READ_LAT + 1, w, d_ref});
        iss[w]++;
      end
      if (e_we) ref_mem[op.addr] = op.wdata;
      m_ovr = (spr_req && m_pend) || (m_ovr && !ovr_clr);
      if (w == OWN_SPR) m_pend = 1'b0;
      else if (spr_req && !m_pend) begin
        m_pend = 1'b1;
        m_paddr = spr_addr;
      end
      if (w == OWN_CPU) void'(cq.pop_front());
      if (cpu_req && e_ready) cq.push_back({cpu_we, cpu_addr, cpu_wdata});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (env_q.size() > 0 && env_q[0].due == cyc) begin
      ev = env_q.pop_front();
      vram_rdata = ev.data;
    end else vram_rdata = {$urandom, $urandom};
  endtask
  task automatic idle_inputs();
    screen_busy = 1'b0; bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0;
    cpu_we = 1'b0; ovr_clr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic set_spr(input logic [13:0] base);
    for (int i = 0; i < 8; i++) spr_addr[i] = base + 14'(i);
  endtask
  initial begin
    int n;
    idle_inputs();
    vram_rdata = '0;
    for (int i = 0; i < 8; i++) bg_addr[i] = 14'h100 + 14'(i);
    set_spr(14'h200);
    @(posedge clk);
    #1;
    do_reset();
    // background and sprite collide while the screen is busy
    screen_busy = 1'b1; bg_req = 1'b1; spr_req = 1'b1;
    step();
    check("s32_c0_rd", s_rd, 1'b1);
    check("s32_c0_addr", s_addr[0], 14'h100);
    bg_req = 1'b0; spr_req = 1'b0;
    step();
    check("s32_c1_addr", s_addr[0], 14'h200);
    step();
    step();
    check("s32_c3_bgv", s_bgv, 1'b1);
    step();
    check("s32_c4_sprv", s_sprv, 1'b1);
    // sprite overrun, then clear, then simultaneous set and clear
    do_reset();
    screen_busy = 1'b1; bg_req = 1'b1; spr_req = 1'b1;
    set_spr(14'h200); step();
    set_spr(14'h300); step();
    check("s35_ovr_c1", s_ovr, 1'b0);
    set_spr(14'h400); step();
    check("s35_ovr_c2", s_ovr, 1'b1);
    bg_req = 1'b0; spr_req = 1'b0; step();
    check("s35_spr_rd", s_rd, 1'b1);
    check("s35_spr_addr", s_addr[0], 14'h200);
    ovr_clr = 1'b1; step();
    ovr_clr = 1'b0; step();
    check("s35_ovr_clr", s_ovr, 1'b0);
    bg_req = 1'b1; spr_req = 1'b1; step();
    ovr_clr = 1'b1; step();
    spr_req = 1'b0; ovr_clr = 1'b0; step();
    check("s35_set_wins", s_ovr, 1'b1);
    bg_req = 1'b0; step(); step(); step();
    // CPU FIFO fills while background owns the bus, then drains
    do_reset();
    screen_busy = 1'b1; bg_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 14'(i);
      cpu_wdata = 8'(16 + i);
      step();
    end
    cpu_addr = 14'h77;
    step();
    check("s34_full_ready", s_ready, 1'b0);
    check("s34_full_count", s_cnt, 3'd4);
    cpu_req = 1'b0; bg_req = 1'b0;
    step();
    check("s34_d0_we", s_we, 1'b1);
    check("s34_d0_addr", s_addr[0], 14'h0);
    step();
    check("s34_d1_ready", s_ready, 1'b1);
    check("s34_d1_count", s_cnt, 3'd3);
    step();
    step();
    check("s34_d3_addr", s_addr[0], 14'h3);
    check("s34_d3_wdata", s_wd, 8'h13);
    step();
    check("s34_drained", s_cnt, 3'd0);
    // read-after-write through the CPU FIFO
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_wdata = 8'hA5;
    step();
    check("s33_c0_ready", s_ready, 1'b1);
    cpu_we = 1'b0;
    step();
    check("s33_c1_we", s_we, 1'b1);
    check("s33_c1_addr", s_addr[0], 14'h3FFF);
    check("s33_c1_wdata", s_wd, 8'hA5);
    cpu_req = 1'b0;
    step();
    check("s33_c2_rd", s_rd, 1'b1);
    check("s33_c2_lane7", s_addr[7], 14'h3FFF);
    step();
    step();
    step();
    check("s33_c5_cpuv", s_cpuv, 1'b1);
    check("s33_c5_rdata", s_rdata[0], 8'hA5);
    // reset right after a background read discards it
    screen_busy = 1'b1; bg_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h5;
    step();
    cpu_req = 1'b0; rst = 1'b1;
    step();
    check("s36_rd", s_rd, 1'b0);
    check("s36_count", s_cnt, 3'd0);
    check("s36_ready", s_ready, 1'b1);
    check("s36_rdata", s_rdata, 64'h0);
    check("s36_ovr", s_ovr, 1'b0);
    step();
    rst = 1'b0; bg_req = 1'b0;
    n = 0;
    repeat (4) begin
      step();
      n += int'(s_bgv);
    end
    check("s36_no_bgv", n, 0);
    for (int k = 0; k < 10000; k++) begin
      rst = $urandom_range(0, 499) == 0;
      screen_busy = 1'($urandom_range(0, 1));
      bg_req = $urandom_range(0, 2) == 0;
      spr_req = $urandom_range(0, 4) == 0;
      cpu_req = 1'($urandom_range(0, 1));
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = raddr();
      cpu_wdata = 8'($urandom);
      ovr_clr = $urandom_range(0, 19) == 0;
      for (int i = 0; i < 8; i++) begin
        bg_addr[i] = raddr();
        spr_addr[i] = raddr();
      end
      step();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (12) step();
    check("bg_reads", rv[OWN_BG], iss[OWN_BG]);
    check("spr_reads", rv[OWN_SPR], iss[OWN_SPR]);
    check("cpu_reads", rv[OWN_CPU], iss[OWN_CPU]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
